mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback and drives the ALU's 12-bit control word {opcode, funct}.
- Drives the shared memory port through a req/ready handshake, and drives register-file, PC and mux selects.
- Sits beside the ALU, register file and PC/IR registers; decodes opcode/funct from the IR.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req may wait for mem_ready before bus error (>=1).
- TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  permits starting a new instruction.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write (valid with mem_req).
- mem_addr_sel  out  1  0=PC, 1=ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  load PC.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target.
- alu_control  out  12  ALU control word.
- alu_src_b  out  1  0=rt register, 1=sign-extended immediate.
- reg_we  out  1  register-file write.
- reg_dst  out  1  0=rt, 1=rd.
- wb_sel  out  1  0=ALU result, 1=memory data.
- retired  out  1  one-cycle pulse when an instruction completes.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode/funct.
- bus_error  out  1  sticky; set on memory timeout.
- state  out  3  current state (debug).

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6.
- Reset (rst_n=0, async): state=IDLE, timeout counter=0. All outputs 0 in IDLE.
- Outputs are decoded from the registered state. ir_we, pc_we (FETCH) and retired are additionally qualified by mem_ready.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE (1 cycle):
  - j (0x02): pc_we=1, pc_src=2, retired=1; go to FETCH if run, else IDLE.
  - Unsupported opcode/funct: illegal_instr=1; go to FETCH if run, else IDLE. The PC is already advanced.
  - Otherwise go to EXEC.
- Supported instructions:
  - R-type op 0x00 with funct add 0x20 or sub 0x22.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- EXEC, alu_control:
  - R-type: {000000, funct}, alu_src_b=0, then WB.
  - addi: 12'b001000_000000, alu_src_b=1, then WB.
  - lw/sw: 12'b001000_000000 (address add), alu_src_b=1, then MEM.
  - beq: {000100, 000000}, alu_src_b=0. If alu_zero: pc_we=1, pc_src=1. retired=1. Go to FETCH/IDLE as for DECODE.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(sw).
  - alu_control and alu_src_b are held at the EXEC values.
  - On mem_ready: sw gives retired=1, then FETCH/IDLE; lw goes to WB.
  - Otherwise hold in MEM.
- WB (1 cycle):
  - reg_we=1, retired=1.
  - R-type: reg_dst=1, wb_sel=0. addi: reg_dst=0, wb_sel=0. lw: reg_dst=0, wb_sel=1.
  - Go to FETCH if run, else IDLE.
- Latency from FETCH entry with zero-wait memory: j=2, beq=3, R-type/addi/sw=4, lw=5 cycles.
- run is sampled only at instruction boundaries. Deasserting run mid-instruction completes that instruction, then enters IDLE.
- Timeout:
  - The counter clears on entry to FETCH/MEM and on mem_ready.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready=0, go to ERROR.
  - mem_ready in the same cycle as the limit wins, i.e. it is a normal completion.
- ERROR: all outputs 0 except bus_error=1 and state=6. Exits only on reset.
- Reset asserted mid-operation: immediate IDLE, outputs 0. No partial writes are signalled after reset.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- addi (opcode 0x08), zero-wait memory, run=1:
  - states 1,2,3,5.
  - alu_control=0x200 in EXEC; reg_we=1, reg_dst=0 in WB.
  - retired pulses at cycle 4.
- lw with mem_ready delayed 3 cycles in MEM:
  - MEM held 4 cycles with mem_req=1, mem_addr_sel=1, mem_we=0.
  - WB then has wb_sel=1.
- beq:
  - alu_zero=1: pc_we=1, pc_src=1 in EXEC.
  - alu_zero=0: pc_we=0.
  - Both cases: retired=1, next state FETCH.
- opcode 0x3F → illegal_instr pulses in DECODE, no reg_we/mem_req, return to FETCH.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → ERROR after 4 wait cycles, bus_error=1 sticky, mem_req=0; only rst_n clears it.
- Deassert run during EXEC of an R-type → WB completes, then IDLE; mem_req=0 until run=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the ALU control word, the shared memory handshake and datapath selects.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [11:0] alu_control,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        wb_sel,
    output logic        retired,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE,
        K_ADDI,
        K_LW,
        K_SW,
        K_BEQ,
        K_JUMP,
        K_ILLEGAL
    } kind_t;

    localparam logic [5:0]      OP_RTYPE = 6'h00;
    localparam logic [5:0]      OP_J     = 6'h02;
    localparam logic [5:0]      OP_BEQ   = 6'h04;
    localparam logic [5:0]      OP_ADDI  = 6'h08;
    localparam logic [5:0]      OP_LW    = 6'h23;
    localparam logic [5:0]      OP_SW    = 6'h2B;
    localparam logic [5:0]      FN_ADD   = 6'h20;
    localparam logic [5:0]      FN_SUB   = 6'h22;
    localparam logic [11:0]     ALU_ADD  = {OP_ADDI, 6'h00};
    localparam logic [11:0]     ALU_BEQ  = {OP_BEQ, 6'h00};
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    kind_t           kind_q, dec_kind;
    logic [5:0]      funct_q;
    logic [TO_W-1:0] to_cnt;
    state_t          boundary;
    logic            mem_expired;

    always_comb begin
        dec_kind = K_ILLEGAL;
        case (opcode)
            OP_RTYPE: if (funct == FN_ADD || funct == FN_SUB) dec_kind = K_RTYPE;
            OP_ADDI:  dec_kind = K_ADDI;
            OP_LW:    dec_kind = K_LW;
            OP_SW:    dec_kind = K_SW;
            OP_BEQ:   dec_kind = K_BEQ;
            OP_J:     dec_kind = K_JUMP;
            default:  dec_kind = K_ILLEGAL;
        endcase
    end

    assign boundary    = run ? S_FETCH : S_IDLE;
    // The limit cycle is the last waiting cycle; mem_ready there still completes normally.
    assign mem_expired = !mem_ready && (to_cnt >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_ILLEGAL;
            funct_q <= '0;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                kind_q  <= dec_kind;
                funct_q <= funct;
            end
            if (state_d != state_q) begin
                to_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = 2'd0;
        alu_control   = '0;
        alu_src_b     = 1'b0;
        reg_we        = 1'b0;
        reg_dst       = 1'b0;
        wb_sel        = 1'b0;
        retired       = 1'b0;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (mem_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                case (dec_kind)
                    K_JUMP: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        retired = 1'b1;
                        state_d = boundary;
                    end
                    K_ILLEGAL: begin
                        illegal_instr = 1'b1;
                        state_d       = boundary;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (kind_q)
                    K_RTYPE: begin
                        alu_control = {OP_RTYPE, funct_q};
                        state_d     = S_WB;
                    end
                    K_ADDI: begin
                        alu_control = ALU_ADD;
                        alu_src_b   = 1'b1;
                        state_d     = S_WB;
                    end
                    K_LW, K_SW: begin
                        alu_control = ALU_ADD;
                        alu_src_b   = 1'b1;
                        state_d     = S_MEM;
                    end
                    K_BEQ: begin
                        alu_control = ALU_BEQ;
                        if (alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                        retired = 1'b1;
                        state_d = boundary;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (kind_q == K_SW);
                alu_control  = ALU_ADD;
                alu_src_b    = 1'b1;
                if (mem_ready) begin
                    if (kind_q == K_SW) begin
                        retired = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (mem_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retired = 1'b1;
                reg_dst = (kind_q == K_RTYPE);
                wb_sel  = (kind_q == K_LW);
                state_d = boundary;
            end
            S_ERROR: begin
                bus_error = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

endmodule
